const_table: RTL and testbench
==============================

CONST_TABLE -- requirements
Module: const_table

Interface
REQ-001 Parameter DATA_W, default 8, width of each constant and read result.
REQ-002 Parameter IDX_W, default 4, table index width; DEPTH = 2**IDX_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 restore  input  1  single-cycle pulse; reload all defaults.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_idx  input  IDX_W  write entry index.
REQ-009 wr_data  input  DATA_W  write value.
REQ-010 wr_err  output  1  one-cycle pulse: write rejected.
REQ-011 rd_ptr  input  NUM_RD x (IDX_W+1)  operand pointer per port; MSB set = constant, MSB clear = register number.
REQ-012 rd_en  input  NUM_RD  read request per port.
REQ-013 rd_data  output  NUM_RD x DATA_W  registered result per port.
REQ-014 rd_const  output  NUM_RD  registered per port: 1 = constant, 0 = register pointer.
REQ-015 rd_valid  output  NUM_RD  registered per port: rd_data/rd_const valid.
REQ-016 ready  output  1  table initialised and usable.

Function
REQ-017 The FSM SHALL have exactly two states, INIT and RUN; reset enters INIT with counter 0.
REQ-018 In INIT, one entry per cycle SHALL be written with DEFAULT_CONST[counter]; after entry DEPTH-1, the next state SHALL be RUN; ready SHALL be 1 in RUN only (DEPTH cycles after reset release).
REQ-019 A restore pulse in RUN SHALL return to INIT with counter 0 and drop ready the next cycle; a restore pulse in INIT SHALL restart the counter at 0.
REQ-020 In RUN, a read on port p with rd_en[p]=1 SHALL produce outputs exactly one cycle later: MSB=1 gives rd_data = table[rd_ptr[IDX_W-1:0]], rd_const = 1; MSB=0 gives rd_data = zero-extended rd_ptr, rd_const = 0.
REQ-021 rd_valid[p] SHALL equal rd_en[p] registered, gated by RUN; with rd_valid low, rd_data and rd_const SHALL hold their last value.
REQ-022 Reads in INIT SHALL give rd_valid = 0 and SHALL NOT change rd_data.
REQ-023 In RUN, wr_en SHALL update table[wr_idx] at the clock edge.
REQ-024 Same-cycle write and constant read of the same index SHALL return wr_data (write-first bypass).
REQ-025 Ports SHALL be independent; multiple ports reading one index in one cycle SHALL all get the same value.
REQ-026 wr_en in INIT SHALL be dropped and SHALL pulse wr_err for one cycle.
REQ-027 If DATA_W < IDX_W+1, passthrough SHALL truncate to the low DATA_W bits.

Reset
REQ-028 Reset_n low SHALL asynchronously force INIT, counter 0, ready 0, wr_err 0, rd_valid all 0, rd_data all 0, rd_const all 0.
REQ-029 Table contents are undefined during reset; init SHALL rewrite every entry after release, including after a reset asserted mid-INIT.

Configuration
REQ-030 With CONST_TABLE_LOCK_EN defined, an extra input lock (1 bit) SHALL exist; in RUN with lock=1, writes SHALL be dropped and pulse wr_err; restore SHALL be ignored while lock=1.
REQ-031 Without CONST_TABLE_LOCK_EN, no lock port SHALL exist and RUN writes are always accepted.

Structure
REQ-032 Package const_table_pkg SHALL hold the state typedef (INIT, RUN) and the DEFAULT_CONST array, indices 0..15: 127,1,2,128,8,3,4,5,32,6,15,64,7,255,16,20. For DEPTH > 16, entries 16 and up SHALL default to 0.
REQ-033 Sub-module const_rd_port (one instance per port) SHALL hold the pointer decode, bypass mux and output registers; the table and FSM SHALL remain in const_table.

Verification
REQ-034 Release reset; ready SHALL rise 16 cycles later; then read ptr 5'b10011 -> rd_data=128, rd_const=1 one cycle later.
REQ-035 In RUN, read ptr 5'b00110 -> rd_data=6, rd_const=0, rd_valid=1.
REQ-036 In RUN, write idx 2 = 0x5A while port 0 reads 5'b10010 and port 1 reads 5'b10010 -> both return 0x5A; the next read also returns 0x5A.
REQ-037 Write during INIT -> wr_err pulses one cycle and the entry keeps its default after ready.
REQ-038 Pulse restore after idx 2 was rewritten -> ready drops; after 16 cycles idx 2 reads 2.
REQ-039 Assert Reset_n low mid-INIT at counter 7 -> outputs clear immediately; a full 16-cycle init follows; with CONST_TABLE_LOCK_EN and lock=1, a write in RUN gives wr_err and no table change.

Source files
------------

// File: rtl/const_table_pkg.sv
// Shared types and power-up constants for the constant table.
// Imported by const_table; the optional CONST_TABLE_LOCK_EN feature lives in the top.
package const_table_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_COUNT = 16;

   localparam logic [7:0] DEFAULT_CONST [DEFAULT_COUNT] = '{
      8'd127, 8'd1,  8'd2,  8'd128, 8'd8, 8'd3,   8'd4,  8'd5,
      8'd32,  8'd6,  8'd15, 8'd64,  8'd7, 8'd255, 8'd16, 8'd20
   };

   // Tables deeper than the default list fill their upper entries with zero.
   function automatic logic [7:0] default_const(input logic [31:0] idx);
      if (idx < 32'(DEFAULT_COUNT))
         return DEFAULT_CONST[idx[3:0]];
      return 8'd0;
   endfunction

endpackage

// File: rtl/const_rd_port.sv
// One read port: pointer decode, write-first bypass and registered outputs.
module const_rd_port #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_run,
   input  logic              i_en,
   input  logic [IDX_W:0]    i_ptr,
   input  logic [DATA_W-1:0] i_tbl_data,
   input  logic              i_wr_fire,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_const,
   output logic              o_valid
);

   logic              w_is_const;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W-1:0] r_data;
   logic              r_const;
   logic              r_valid;

   assign w_is_const = i_ptr[IDX_W];
   assign w_idx      = i_ptr[IDX_W-1:0];

   // NOTE: default assigned first so every path drives w_data and no latch is inferred.
   always_comb begin
      w_data = i_tbl_data;
      if (!w_is_const)
         w_data = DATA_W'(w_idx);
      else if (i_wr_fire && (i_wr_idx == w_idx))
         w_data = i_wr_data;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_const <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_en & i_run;
         if (i_en && i_run) begin
            r_data  <= w_data;
            r_const <= w_is_const;
         end
      end
   end

   assign o_data  = r_data;
   assign o_const = r_const;
   assign o_valid = r_valid;

endmodule

// File: rtl/const_table.sv
// Writable constant table with power-up init FSM and NUM_RD operand read ports.
// Define CONST_TABLE_LOCK_EN to add a lock input that freezes writes and restore.
module const_table
   import const_table_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4,
   parameter int NUM_RD = 2
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       restore,
`ifdef CONST_TABLE_LOCK_EN
   input  logic                       lock,
`endif
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_err,
   input  logic [NUM_RD*(IDX_W+1)-1:0] rd_ptr,
   input  logic [NUM_RD-1:0]          rd_en,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_const,
   output logic [NUM_RD-1:0]          rd_valid,
   output logic                       ready
);

   localparam int DEPTH = 2 ** IDX_W;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  w_cnt_nxt;
   logic              r_wr_err;
   logic              w_locked;
   logic              w_restore;
   logic              w_wr_fire;
   logic [DATA_W-1:0] r_table [DEPTH];

`ifdef CONST_TABLE_LOCK_EN
   assign w_locked = lock;
`else
   assign w_locked = 1'b0;
`endif

   assign w_restore = restore & ~w_locked;
   assign w_wr_fire = wr_en & (r_state == RUN) & ~w_locked;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         INIT: begin
            if (w_restore) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == IDX_W'(DEPTH - 1)) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + IDX_W'(1);
            end
         end
         RUN: begin
            if (w_restore) begin
               w_state_nxt = INIT;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state  <= INIT;
         r_cnt    <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_wr_err <= wr_en & ~w_wr_fire;
      end
   end

   // NOTE: the table has no reset; INIT rewrites every entry after reset release.
   always_ff @(posedge Clk) begin
      if (r_state == INIT)
         r_table[r_cnt] <= DATA_W'(default_const(32'(r_cnt)));
      else if (w_wr_fire)
         r_table[wr_idx] <= wr_data;
   end

   assign ready  = (r_state == RUN);
   assign wr_err = r_wr_err;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      logic [IDX_W:0] w_ptr;
      assign w_ptr = rd_ptr[p*(IDX_W+1) +: (IDX_W+1)];

      const_rd_port #(
         .DATA_W (DATA_W),
         .IDX_W  (IDX_W)
      ) u_port (
         .i_clk      (Clk),
         .i_rst_n    (Reset_n),
         .i_run      (r_state == RUN),
         .i_en       (rd_en[p]),
         .i_ptr      (w_ptr),
         .i_tbl_data (r_table[w_ptr[IDX_W-1:0]]),
         .i_wr_fire  (w_wr_fire),
         .i_wr_idx   (wr_idx),
         .i_wr_data  (wr_data),
         .o_data     (rd_data[p*DATA_W +: DATA_W]),
         .o_const    (rd_const[p]),
         .o_valid    (rd_valid[p])
      );
   end

endmodule

// File: tb/tb_const_table.sv
// Directed bench for const_table: init timing, reads, bypass, restore, reset mid-init.
module tb_const_table;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        restore;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [7:0]  wr_data;
   logic        wr_err;
   logic [9:0]  rd_ptr;
   logic [1:0]  rd_en;
   logic [15:0] rd_data;
   logic [1:0]  rd_const;
   logic [1:0]  rd_valid;
   logic        ready;
`ifdef CONST_TABLE_LOCK_EN
   logic        lock;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   const_table #(.DATA_W(8), .IDX_W(4), .NUM_RD(2)) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .restore  (restore),
`ifdef CONST_TABLE_LOCK_EN
      .lock     (lock),
`endif
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .wr_err   (wr_err),
      .rd_ptr   (rd_ptr),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_const (rd_const),
      .rd_valid (rd_valid),
      .ready    (ready)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(negedge Clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      restore = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      rd_en   = 2'b11;
      rd_ptr  = {5'b10011, 5'b10011};
`ifdef CONST_TABLE_LOCK_EN
      lock    = 1'b0;
`endif
      tick(2);
      check("rst_ready",    32'(ready),    32'h0);
      check("rst_wr_err",   32'(wr_err),   32'h0);
      check("rst_valid",    32'(rd_valid), 32'h0);
      check("rst_data",     32'(rd_data),  32'h0);
      check("rst_const",    32'(rd_const), 32'h0);

      // Release reset with a write and reads pending during INIT.
      Reset_n = 1'b1;
      wr_en   = 1'b1;
      wr_idx  = 4'd3;
      wr_data = 8'hAA;
      tick();
      check("init_wr_err",  32'(wr_err),   32'h1);
      check("init_valid",   32'(rd_valid), 32'h0);
      check("init_data",    32'(rd_data),  32'h0);
      wr_en = 1'b0;
      tick();
      check("init_wr_err_1cyc", 32'(wr_err), 32'h0);
      tick(13);
      check("ready_c15",    32'(ready),    32'h0);
      tick();
      check("ready_c16",    32'(ready),    32'h1);
      check("init_last_valid", 32'(rd_valid), 32'h0);
      tick();
      check("const3_valid", 32'(rd_valid), 32'h3);
      check("const3_data",  32'(rd_data),  32'h8080);
      check("const3_const", 32'(rd_const), 32'h3);

      // Passthrough on port 0, constant 13 on port 1.
      rd_ptr = {5'b11101, 5'b00110};
      tick();
      check("pass6_data",   32'(rd_data),  32'hFF06);
      check("pass6_const",  32'(rd_const), 32'h2);
      check("pass6_valid",  32'(rd_valid), 32'h3);

      // No request: outputs hold.
      rd_en  = 2'b00;
      rd_ptr = {5'b10000, 5'b10000};
      tick();
      check("hold_valid",   32'(rd_valid), 32'h0);
      check("hold_data",    32'(rd_data),  32'hFF06);
      check("hold_const",   32'(rd_const), 32'h2);

      // Write-first bypass to both ports.
      wr_en   = 1'b1;
      wr_idx  = 4'd2;
      wr_data = 8'h5A;
      rd_en   = 2'b11;
      rd_ptr  = {5'b10010, 5'b10010};
      tick();
      check("bypass_data",  32'(rd_data),  32'h5A5A);
      check("bypass_const", 32'(rd_const), 32'h3);
      check("run_wr_err",   32'(wr_err),   32'h0);
      wr_en = 1'b0;
      tick();
      check("after_wr_data", 32'(rd_data), 32'h5A5A);

      // Port independence.
      rd_en  = 2'b01;
      rd_ptr = {5'b10000, 5'b10000};
      tick();
      check("p0_only_valid", 32'(rd_valid), 32'h1);
      check("p0_only_data",  32'(rd_data),  32'h5A7F);

      rd_en  = 2'b11;
      rd_ptr = {5'b00000, 5'b01111};
      tick();
      check("pass_edge_data",  32'(rd_data),  32'h000F);
      check("pass_edge_const", 32'(rd_const), 32'h0);

      // Restore in RUN, then again mid-INIT.
      rd_en   = 2'b00;
      restore = 1'b1;
      tick();
      check("restore_ready", 32'(ready), 32'h0);
      restore = 1'b0;
      tick(5);
      restore = 1'b1;
      tick();
      restore = 1'b0;
      check("rerestore_ready", 32'(ready), 32'h0);
      tick(15);
      check("restore_c15",   32'(ready), 32'h0);
      tick();
      check("restore_c16",   32'(ready), 32'h1);
      rd_en  = 2'b11;
      rd_ptr = {5'b10011, 5'b10010};
      tick();
      check("restored_data", 32'(rd_data), 32'h8002);

      // Dirty entry 13, then reset during INIT at counter 7.
      wr_en   = 1'b1;
      wr_idx  = 4'd13;
      wr_data = 8'h11;
      rd_ptr  = {5'b11101, 5'b10100};
      tick();
      check("wr13_data",     32'(rd_data), 32'h1108);
      wr_en   = 1'b0;
      rd_en   = 2'b00;
      restore = 1'b1;
      tick();
      restore = 1'b0;
      tick(7);
      Reset_n = 1'b0;
      #1;
      check("async_data",    32'(rd_data),  32'h0);
      check("async_const",   32'(rd_const), 32'h0);
      check("async_valid",   32'(rd_valid), 32'h0);
      check("async_ready",   32'(ready),    32'h0);
      tick();
      Reset_n = 1'b1;
      tick(15);
      check("reinit_c15",    32'(ready), 32'h0);
      tick();
      check("reinit_c16",    32'(ready), 32'h1);
      rd_en  = 2'b11;
      rd_ptr = {5'b11101, 5'b10100};
      tick();
      check("reinit_data",   32'(rd_data), 32'hFF08);

`ifdef CONST_TABLE_LOCK_EN
      lock    = 1'b1;
      rd_en   = 2'b00;
      wr_en   = 1'b1;
      wr_idx  = 4'd5;
      wr_data = 8'h99;
      tick();
      check("lock_wr_err",   32'(wr_err), 32'h1);
      wr_en   = 1'b0;
      restore = 1'b1;
      tick();
      check("lock_restore_ready", 32'(ready), 32'h1);
      restore = 1'b0;
      lock    = 1'b0;
      rd_en   = 2'b01;
      rd_ptr  = {5'b10000, 5'b10101};
      tick();
      check("lock_entry5",   32'(rd_data[7:0]), 32'h03);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
